// File: rtl/fifo_rd_arbiter.sv
// Read-side arbiter for the async FIFO: round-robin grant among N_REQ consumers,
// bounded read bursts gated by the empty flag, one-hot steering of returning words.
module fifo_rd_arbiter #(
    parameter int N_REQ  = 4,
    parameter int BURST  = 4,
    parameter int DATA_W = 8
) (
    input  logic              i_rclk,
    input  logic              i_rst,
    input  logic [N_REQ-1:0]  i_req,
    input  logic              i_empty,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_ren,
    output logic [N_REQ-1:0]  o_gnt,
    output logic [N_REQ-1:0]  o_rvalid,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy
);
    localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_TAIL} state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  rvalid_q, rvalid_d;
    logic [RR_W-1:0]   gidx_q, gidx_d;
    logic [RR_W-1:0]   rr_q, rr_d;
    logic [3:0]        cnt_q, cnt_d;

    logic              pick_found;
    logic [RR_W-1:0]   pick_idx;
    int                scan_k;
    logic              ren;

    // Scan upward from rr, wrapping, for the first active request.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_q;
        scan_k     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_k = int'(rr_q) + i;
            if (scan_k >= N_REQ) scan_k = scan_k - N_REQ;
            if (!pick_found && i_req[scan_k]) begin
                pick_found = 1'b1;
                pick_idx   = RR_W'(scan_k);
            end
        end
    end

    assign ren = (state_q == S_BURST) && !i_empty && (|(i_req & gnt_q))
                 && (cnt_q != 4'(BURST));

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gidx_d   = gidx_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        rvalid_d = ren ? gnt_q : '0;
        case (state_q)
            S_IDLE: begin
                if ((|i_req) && !i_empty && pick_found) begin
                    gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    gidx_d  = pick_idx;
                    cnt_d   = 4'd0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (ren) cnt_d = cnt_q + 4'd1;
                if (!ren || (cnt_q + 4'd1 == 4'(BURST))) state_d = S_TAIL;
            end
            S_TAIL: begin
                // rr advances even for a zero-word burst so an idle grant still rotates
                gnt_d   = '0;
                rr_d    = (gidx_q == RR_W'(N_REQ-1)) ? '0 : gidx_q + 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_rclk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            rvalid_q <= '0;
            gidx_q   <= '0;
            rr_q     <= '0;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            gidx_q   <= gidx_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_ren    = ren;
    assign o_gnt    = gnt_q;
    assign o_rvalid = rvalid_q;
    assign o_rdata  = i_rdata;
    assign o_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: FIFO model feeds the read port, a scoreboard of
// expected (consumer, word) pairs is checked against every o_rvalid pulse.
module tb_fifo_rd_arbiter;
    logic       i_rclk = 1'b0;
    logic       i_rst  = 1'b1;
    logic [3:0] i_req  = 4'd0;
    logic       i_empty = 1'b1;
    logic [7:0] i_rdata = 8'd0;
    logic       o_ren;
    logic [3:0] o_gnt;
    logic [3:0] o_rvalid;
    logic [7:0] o_rdata;
    logic       o_busy;

    typedef struct packed {
        logic [3:0] v;
        logic [7:0] d;
    } exp_t;

    logic [7:0] mem[$];
    exp_t       exp_q[$];
    logic [7:0] wseq = 8'h10;
    logic [7:0] eseq = 8'h10;
    int         nchk = 0;
    int         nerr = 0;

    fifo_rd_arbiter #(.N_REQ(4), .BURST(4), .DATA_W(8)) dut (
        .i_rclk(i_rclk), .i_rst(i_rst), .i_req(i_req), .i_empty(i_empty),
        .i_rdata(i_rdata), .o_ren(o_ren), .o_gnt(o_gnt), .o_rvalid(o_rvalid),
        .o_rdata(o_rdata), .o_busy(o_busy)
    );

    always #5 i_rclk = ~i_rclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // FIFO model: data registered on o_ren, empty flag registered after the pop.
    always @(posedge i_rclk) begin
        if (o_ren && !i_rst) begin
            if (mem.size() == 0) chk("pop_empty_fifo", 1, 0);
            else i_rdata <= mem.pop_front();
        end
        #1 i_empty = (mem.size() == 0);
    end

    always @(negedge i_rclk) begin
        if (o_ren) chk("ren_while_empty", i_empty, 0);
        if (o_gnt != 0) chk("gnt_onehot", $onehot(o_gnt), 1);
        if (o_rvalid != 0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", o_rvalid, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rvalid_steer", o_rvalid, e.v);
                chk("rdata", o_rdata, e.d);
            end
        end
    end

    task automatic tick();
        @(posedge i_rclk);
        #2;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            mem.push_back(wseq);
            wseq++;
        end
    endtask

    task automatic expect_words(input logic [3:0] v, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.v = v;
            e.d = eseq;
            eseq++;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        i_req = 4'd0;
        repeat (3) tick();
        chk(tag, exp_q.size(), 0);
    endtask

    logic [11:0] ren_pat, busy_pat, ren_exp, busy_exp;
    logic [4:0]  ren5, busy5, ren5_exp, busy5_exp;
    logic [3:0]  gnt_seq[$];
    logic [3:0]  prev_gnt;
    int          nidle;

    initial begin
        // reset state
        tick();
        chk("rst_outputs", {o_ren, o_gnt, o_rvalid, o_busy}, 0);
        do_reset();
        chk("post_rst_idle", {o_ren, o_gnt, o_busy}, 0);

        // single requester, 6 words: full burst, TAIL, IDLE, short burst
        load(6);
        expect_words(4'b0001, 6);
        tick();
        i_req = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            tick();
            ren_pat[i]  = o_ren;
            busy_pat[i] = o_busy;
        end
        ren_exp  = 12'b000011001111;
        busy_exp = 12'b001111011111;
        chk("single_ren_pattern", ren_pat, ren_exp);
        chk("single_busy_pattern", busy_pat, busy_exp);
        drain_check("single_sb_drain");

        // round robin with a FIFO that stays fed for five bursts
        do_reset();
        load(20);
        expect_words(4'b0001, 4);
        expect_words(4'b0010, 4);
        expect_words(4'b0100, 4);
        expect_words(4'b1000, 4);
        expect_words(4'b0001, 4);
        tick();
        i_req = 4'b1111;
        prev_gnt = 4'd0;
        nidle = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!o_busy) nidle++;
            if (o_gnt != 0 && o_gnt != prev_gnt) gnt_seq.push_back(o_gnt);
            prev_gnt = o_gnt;
        end
        chk("rr_num_grants", gnt_seq.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < gnt_seq.size()) chk("rr_grant_order", gnt_seq[i], 4'b0001 << (i % 4));
        end
        chk("rr_idle_cycles", nidle, 5);
        drain_check("rr_sb_drain");

        // empty rises after two reads
        do_reset();
        load(2);
        expect_words(4'b0001, 2);
        tick();
        i_req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            ren5[i]  = o_ren;
            busy5[i] = o_busy;
        end
        ren5_exp  = 5'b00011;
        busy5_exp = 5'b01111;
        chk("empty_ren_pattern", ren5, ren5_exp);
        chk("empty_busy_pattern", busy5, busy5_exp);
        load(4);
        expect_words(4'b0010, 4);
        tick();
        i_req = 4'b1111;
        tick();
        chk("empty_rr_advanced", o_gnt, 4'b0010);
        repeat (6) tick();
        drain_check("empty_sb_drain");

        // requester 0 withdraws after one read
        do_reset();
        load(5);
        expect_words(4'b0001, 1);
        expect_words(4'b0010, 4);
        tick();
        i_req = 4'b0011;
        tick();
        tick();
        i_req = 4'b0010;
        #1;
        chk("withdraw_ren_drop", o_ren, 0);
        tick();
        chk("withdraw_tail_gnt", o_gnt, 4'b0001);
        tick();
        chk("withdraw_idle_gnt", o_gnt, 4'b0000);
        tick();
        chk("withdraw_next_gnt", o_gnt, 4'b0010);
        repeat (6) tick();
        drain_check("withdraw_sb_drain");

        // no data: requests held, nothing granted
        i_req = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("nodata_quiet", {o_ren, o_gnt, o_busy}, 0);
        end
        i_req = 4'b0000;

        // asynchronous reset during a read cycle
        load(3);
        tick();
        i_req = 4'b0010;
        tick();
        chk("rstmid_ren_before", o_ren, 1);
        chk("rstmid_gnt_before", o_gnt, 4'b0010);
        @(negedge i_rclk);
        i_rst = 1'b1;
        #1;
        chk("rstmid_immediate", {o_ren, o_gnt, o_rvalid, o_busy}, 0);
        tick();
        chk("rstmid_no_rvalid", o_rvalid, 0);
        tick();
        i_rst = 1'b0;
        chk("rstmid_fifo_kept", mem.size(), 3);
        expect_words(4'b0001, 3);
        i_req = 4'b1111;
        tick();
        chk("rstmid_first_gnt", o_gnt, 4'b0001);
        repeat (6) tick();
        drain_check("rstmid_sb_drain");

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/fifo_rd_arbiter.md
# fifo_rd_arbiter

Read-side arbiter for the asynchronous FIFO. It shares the single FIFO read port among `N_REQ` consumers in the read clock domain. It grants one requester at a time in round-robin order and issues bounded read bursts, gated by the FIFO empty flag. Each returning data word is steered to the granted consumer through a one-hot valid. The block sits between the read-pointer/empty-flag logic plus read-data port and the downstream consumers.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `BURST`, 4, maximum words read per grant (1..15)
- `DATA_W`, 8, FIFO data width
- `i_rclk`  in  1  read-domain clock
- `i_rst`  in  1  reset, asynchronous, active-high
- `i_req`  in  N_REQ  level request per consumer; bit k = consumer k wants data
- `i_empty`  in  1  FIFO registered empty flag (1 = no readable word)
- `i_rdata`  in  DATA_W  FIFO read data, valid the cycle after `o_ren`
- `o_ren`  out  1  FIFO read enable
- `o_gnt`  out  N_REQ  one-hot current grant; all zero when idle
- `o_rvalid`  out  N_REQ  one-hot: `o_rdata` belongs to consumer k this cycle
- `o_rdata`  out  DATA_W  equals `i_rdata` (pass-through)
- `o_busy`  out  1  1 when state is not IDLE

## Operation
- Reset values: state=IDLE, `o_gnt`=0, `o_rvalid`=0, `o_busy`=0, burst counter=0, round-robin pointer `rr`=0. `o_ren`=0 during and after reset.
- States: IDLE, BURST, TAIL.
- IDLE:
  - If `i_req`≠0 and `i_empty`=0: select the first set `i_req` bit scanning upward from index `rr`, wrapping modulo N_REQ. Register it into `o_gnt`, clear the counter, go to BURST.
  - Otherwise stay in IDLE.
- BURST:
  - `o_ren` = `~i_empty & i_req[g] & (cnt != BURST)`, where g is the granted index. This is combinational, so it reacts to `i_empty` in the same cycle.
  - On each `o_ren`=1 cycle, cnt increments (width 4 bits, no wrap possible).
  - Go to TAIL at the end of any cycle where `o_ren`=0, or where `o_ren`=1 and cnt+1 == BURST.
- TAIL:
  - One cycle, `o_ren`=0, `o_gnt` held so the last in-flight word is steered.
  - Next state is IDLE. `o_gnt` is cleared and `rr` becomes (g+1) mod N_REQ.
- Steering: `o_rvalid` is registered: `o_rvalid <= o_ren ? o_gnt : 0`. `o_rdata` = `i_rdata` combinationally.
- Fairness rules:
  - A granted requester keeps the port for at most BURST words.
  - `rr` advances even if zero words were read (e.g. `i_empty` rose between IDLE and BURST).
- Requester dropping `i_req[g]` mid-burst ends the burst (via `o_ren`=0). Data already requested is still delivered in the next cycle.
- Requests from non-granted consumers are ignored until IDLE.
- Reset mid-operation: immediate return to reset values. An in-flight word is dropped (`o_rvalid` forced 0).

## Timing
- Arbitration latency: request and `i_empty`=0 sampled at edge n put the block in BURST. The first `o_ren` can occur in cycle n, and data with `o_rvalid` appears in cycle n+1.
- Read data latency: `o_rvalid` asserts exactly 1 cycle after each `o_ren`, with the same one-hot as `o_gnt` at that `o_ren`.
- Back-to-back reads within a burst: one word per cycle while not empty.
- Grant overhead per burst: 1 IDLE cycle + 1 TAIL cycle. A full burst occupies BURST+2 cycles.
- `o_ren` is never 1 while `i_empty`=1, in IDLE or TAIL, or when `o_gnt`=0.
- `o_gnt` and `o_rvalid` are always one-hot or zero.

## Test plan
- Single requester, long run: `i_req`=0001, FIFO holds 6 words, BURST=4.
  - Expect `o_ren` high for 4 cycles, then TAIL, then IDLE.
  - Expect a re-grant to 0, 2 reads, then `i_empty`=1 stops reads.
  - `o_rvalid`=0001 exactly 6 cycles, each 1 cycle after `o_ren`, with data in FIFO order.
- Round-robin: `i_req`=1111, FIFO never empty.
  - Grant order 0,1,2,3,0.
  - Each grant gives 4 `o_rvalid` pulses to the matching bit; `o_busy` stays 1 except the IDLE arbitration cycles.
- Empty mid-burst: `i_empty` rises after 2 reads.
  - `o_ren` drops in the same cycle and the block goes to TAIL.
  - The second word is still delivered with `o_rvalid`, then IDLE; `rr` has advanced to 1.
- Requester withdraw: `i_req`=0011 and requester 0 drops after 1 read.
  - Burst ends after 1 word; next grant is 1.
- No data: `i_req`=1111 with `i_empty`=1 for 20 cycles.
  - State stays IDLE, `o_ren`=0, `o_gnt`=0.
- Reset mid-burst: assert `i_rst` asynchronously during the BURST cycle with `o_ren`=1.
  - All outputs go to 0 immediately; no `o_rvalid` follows.
  - After release, the first grant goes to requester 0 if it requests.
